// File: rtl/demultiplexador_tdm_pkg.sv
// demultiplexador_tdm_pkg: shared channel count, FSM state and origin tag types for the TDM select/demux path
package demultiplexador_tdm_pkg;
  localparam int N_CANAIS = 8;
  typedef enum logic {OCIOSO, RECEBENDO} estado_t;
  typedef logic [2:0] origem_t;
endpackage

// File: rtl/demultiplexador_tdm_banco_registros.sv
// banco_registros: 8 x LARGURA register bank; clk, reset (sync high), we, addr, din in; q flat bank out (channel i at q[i*LARGURA +: LARGURA])
module banco_registros
  import demultiplexador_tdm_pkg::*;
#(
  parameter int LARGURA = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          we,
  input  logic [2:0]                    addr,
  input  logic [LARGURA-1:0]            din,
  output logic [N_CANAIS*LARGURA-1:0]   q
);
  always_ff @(posedge clk)
    if (reset) q <= '0;
    else if (we) q[addr*LARGURA +: LARGURA] <= din;
endmodule

// File: rtl/demultiplexador_tdm.sv
// demultiplexador_tdm: rebuilds 8 channels from a tagged TDM stream; in clk, reset, ENTRADA, ORIGEM, VALIDO, LIMPA_ERRO; out D0..D7, PREENCHIDO, QUADRO_OK, ERRO
module demultiplexador_tdm
  import demultiplexador_tdm_pkg::*;
#(
  parameter int LARGURA = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [LARGURA-1:0] ENTRADA,
  input  logic [2:0]         ORIGEM,
  input  logic               VALIDO,
  input  logic               LIMPA_ERRO,
  output logic [LARGURA-1:0] D0,
  output logic [LARGURA-1:0] D1,
  output logic [LARGURA-1:0] D2,
  output logic [LARGURA-1:0] D3,
  output logic [LARGURA-1:0] D4,
  output logic [LARGURA-1:0] D5,
  output logic [LARGURA-1:0] D6,
  output logic [LARGURA-1:0] D7,
  output logic [7:0]         PREENCHIDO,
  output logic               QUADRO_OK,
  output logic               ERRO
);
  logic [N_CANAIS*LARGURA-1:0] q;
  estado_t estado, estado_n;
  origem_t esperado, esperado_n;
  logic [7:0] preenchido_n;
  logic quadro_ok_n, erro_ev;
  banco_registros #(.LARGURA(LARGURA)) u_banco (
    .clk(clk), .reset(reset), .we(VALIDO), .addr(ORIGEM), .din(ENTRADA), .q(q)
  );
  assign D0 = q[0*LARGURA +: LARGURA];
  assign D1 = q[1*LARGURA +: LARGURA];
  assign D2 = q[2*LARGURA +: LARGURA];
  assign D3 = q[3*LARGURA +: LARGURA];
  assign D4 = q[4*LARGURA +: LARGURA];
  assign D5 = q[5*LARGURA +: LARGURA];
  assign D6 = q[6*LARGURA +: LARGURA];
  assign D7 = q[7*LARGURA +: LARGURA];
  // ORIGEM 0 always opens a new frame; it is only an error when it interrupts one in progress
  always_comb begin
    estado_n = estado;
    esperado_n = esperado;
    preenchido_n = PREENCHIDO;
    quadro_ok_n = 1'b0;
    erro_ev = 1'b0;
    if (VALIDO) begin
      if (estado == RECEBENDO && ORIGEM == esperado) begin
        preenchido_n = PREENCHIDO | (8'b1 << ORIGEM);
        esperado_n = esperado + 3'd1;
        quadro_ok_n = ORIGEM == 3'd7;
        estado_n = ORIGEM == 3'd7 ? OCIOSO : RECEBENDO;
      end else if (ORIGEM == 3'd0) begin
        erro_ev = estado == RECEBENDO;
        preenchido_n = 8'h01;
        esperado_n = 3'd1;
        estado_n = RECEBENDO;
      end else begin
        erro_ev = 1'b1;
        estado_n = OCIOSO;
      end
    end
  end
  always_ff @(posedge clk)
    if (reset) begin
      estado <= OCIOSO;
      esperado <= 3'd0;
      PREENCHIDO <= 8'h00;
      QUADRO_OK <= 1'b0;
      ERRO <= 1'b0;
    end else begin
      estado <= estado_n;
      esperado <= esperado_n;
      PREENCHIDO <= preenchido_n;
      QUADRO_OK <= quadro_ok_n;
      ERRO <= erro_ev | (ERRO & ~LIMPA_ERRO);
    end
endmodule
